// File: rtl/clint_timer_if.sv
// Request/response bus between a master and the CLINT timer block.
// This is a single-outstanding valid/ready port.
interface clint_timer_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [15:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, resp_ready_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
  );
endinterface

// File: rtl/clint_timer.sv
// Core-local interruptor: a 64-bit mtime/mtimecmp machine timer and an msip software interrupt.
// Both are memory-mapped on a valid/ready slave port with a 1-cycle response.
module clint_timer #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  clint_timer_if.slave   bus,
  output logic           irq_timer_o,
  output logic           irq_software_o
);
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic {ST_IDLE, ST_RESP} state_t;

  state_t        r_state, w_state_nxt;
  logic [PW-1:0] r_presc;
  logic          w_tick;
  logic [63:0]   r_mtime, r_mtimecmp;
  logic          r_msip, r_irq_timer;
  logic [31:0]   r_rdata, w_rdata;
  logic          r_err, w_err;
  logic          w_accept, w_wr;
  logic          w_hit_msip, w_hit_cmp_lo, w_hit_cmp_hi, w_hit_mt_lo, w_hit_mt_hi;

  assign bus.req_ready_o  = (r_state == ST_IDLE) || bus.resp_ready_i;
  assign bus.resp_valid_o = (r_state == ST_RESP);
  assign bus.resp_rdata_o = r_rdata;
  assign bus.resp_err_o   = r_err;
  assign irq_timer_o      = r_irq_timer;
  assign irq_software_o   = r_msip;

  assign w_accept = bus.req_valid_i && bus.req_ready_o;
  assign w_wr     = w_accept && bus.req_we_i && !w_err;
  assign w_tick   = (r_presc == PRESC_MAX);

  // Address decode and read mux; read data reflects pre-edge register values
  always_comb begin
    w_err        = 1'b0;
    w_rdata      = 32'd0;
    w_hit_msip   = 1'b0;
    w_hit_cmp_lo = 1'b0;
    w_hit_cmp_hi = 1'b0;
    w_hit_mt_lo  = 1'b0;
    w_hit_mt_hi  = 1'b0;
    if (bus.req_addr_i[1:0] != 2'b00) begin
      w_err = 1'b1;
    end else begin
      case (bus.req_addr_i)
        16'h0000: begin w_hit_msip   = 1'b1; w_rdata = {31'd0, r_msip}; end
        16'h4000: begin w_hit_cmp_lo = 1'b1; w_rdata = r_mtimecmp[31:0]; end
        16'h4004: begin w_hit_cmp_hi = 1'b1; w_rdata = r_mtimecmp[63:32]; end
        16'hBFF8: begin w_hit_mt_lo  = 1'b1; w_rdata = r_mtime[31:0]; end
        16'hBFFC: begin w_hit_mt_hi  = 1'b1; w_rdata = r_mtime[63:32]; end
        default:  w_err = 1'b1;
      endcase
    end
  end

  // Response state: a new accept always (re)loads RESP
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_RESP;
      ST_RESP: begin
        if (w_accept)              w_state_nxt = ST_RESP;
        else if (bus.resp_ready_i) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_rdata <= (bus.req_we_i || w_err) ? 32'd0 : w_rdata;
      r_err   <= w_err;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       r_presc <= '0;
    else if (w_tick) r_presc <= '0;
    else             r_presc <= r_presc + PW'(1);
  end

  // A software write to either half suppresses that cycle's increment
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                     r_mtime <= 64'd0;
    else if (w_wr && w_hit_mt_lo)  r_mtime[31:0]  <= bus.req_wdata_i;
    else if (w_wr && w_hit_mt_hi)  r_mtime[63:32] <= bus.req_wdata_i;
    else if (w_tick)               r_mtime <= r_mtime + 64'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mtimecmp  <= 64'hFFFF_FFFF_FFFF_FFFF;
      r_msip      <= 1'b0;
      r_irq_timer <= 1'b0;
    end else begin
      if (w_wr && w_hit_cmp_lo) r_mtimecmp[31:0]  <= bus.req_wdata_i;
      if (w_wr && w_hit_cmp_hi) r_mtimecmp[63:32] <= bus.req_wdata_i;
      if (w_wr && w_hit_msip)   r_msip <= bus.req_wdata_i[0];
      r_irq_timer <= (r_mtime >= r_mtimecmp);
    end
  end
endmodule

// File: tb/tb_clint_timer.sv
// Bench for clint_timer: directed scenarios with literal expectations plus random bus traffic,
// checked every cycle against a cycle-count based reference model.
module tb_clint_timer;
  localparam int unsigned TD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq_t, irq_s;
  always #5 clk = ~clk;

  clint_timer_if bus ();

  clint_timer #(.TICK_DIV(TD)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .bus            (bus),
    .irq_timer_o    (irq_t),
    .irq_software_o (irq_s)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Reference model: mtime advances on every TD-th cycle after reset release
  bit [63:0] m_mtime, m_cmp;
  longint unsigned m_cyc;
  bit m_msip, m_irq, m_rv, m_err;
  bit [31:0] m_rd;

  task automatic model_step();
    bit acc, tick, mt_wr, er;
    bit [31:0] rd;
    if (rst) begin
      m_mtime = 64'd0; m_cmp = '1; m_cyc = 0;
      m_msip = 1'b0; m_irq = 1'b0; m_rv = 1'b0; m_err = 1'b0; m_rd = 32'd0;
      return;
    end
    acc   = bus.req_valid_i && (!m_rv || bus.resp_ready_i);
    tick  = (m_cyc % TD) == longint'(TD - 1);
    m_cyc++;
    m_irq = (m_mtime >= m_cmp);
    mt_wr = 1'b0;
    if (acc) begin
      rd = 32'd0; er = 1'b0;
      if (bus.req_addr_i[1:0] != 2'b00) er = 1'b1;
      else begin
        case (bus.req_addr_i)
          16'h0000: begin rd = {31'd0, m_msip};
                          if (bus.req_we_i) m_msip = bus.req_wdata_i[0]; end
          16'h4000: begin rd = m_cmp[31:0];
                          if (bus.req_we_i) m_cmp[31:0] = bus.req_wdata_i; end
          16'h4004: begin rd = m_cmp[63:32];
                          if (bus.req_we_i) m_cmp[63:32] = bus.req_wdata_i; end
          16'hBFF8: begin rd = m_mtime[31:0];
                          if (bus.req_we_i) begin m_mtime[31:0] = bus.req_wdata_i; mt_wr = 1'b1; end end
          16'hBFFC: begin rd = m_mtime[63:32];
                          if (bus.req_we_i) begin m_mtime[63:32] = bus.req_wdata_i; mt_wr = 1'b1; end end
          default:  er = 1'b1;
        endcase
      end
      if (bus.req_we_i || er) rd = 32'd0;
      m_rv = 1'b1; m_rd = rd; m_err = er;
    end else if (bus.resp_ready_i) begin
      m_rv = 1'b0;
    end
    if (!mt_wr && tick) m_mtime = m_mtime + 64'd1;
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("req_ready", 32'(bus.req_ready_o), 32'(!m_rv || bus.resp_ready_i));
      chk("resp_valid", 32'(bus.resp_valid_o), 32'(m_rv));
      if (m_rv) begin
        chk("resp_rdata", bus.resp_rdata_o, m_rd);
        chk("resp_err", 32'(bus.resp_err_o), 32'(m_err));
      end
      chk("irq_timer", 32'(irq_t), 32'(m_irq));
      chk("irq_software", 32'(irq_s), 32'(m_msip));
    end
  end

  // One transaction with resp_ready held high; returns after the response is consumed
  task automatic xfer(input logic we, input logic [15:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic er);
    int n;
    bus.req_valid_i = 1'b1; bus.req_we_i = we; bus.req_addr_i = a; bus.req_wdata_i = d;
    bus.resp_ready_i = 1'b1;
    n = 0;
    #1;
    while (!bus.req_ready_o && n < 50) begin @(posedge clk); #2; n++; end
    if (n >= 50) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #2;
    bus.req_valid_i = 1'b0;
    chk("xfer_resp_valid", 32'(bus.resp_valid_o), 32'd1);
    rd = bus.resp_rdata_o;
    er = bus.resp_err_o;
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  logic [31:0] rd;
  logic er;
  bit [15:0] alist [8] = '{16'h0000, 16'h0004, 16'h4000, 16'h4004,
                           16'h4002, 16'hBFF8, 16'hBFFC, 16'h1234};

  initial begin
    int n;
    bit held;
    bus.req_valid_i = 1'b0; bus.req_we_i = 1'b0; bus.req_addr_i = 16'd0;
    bus.req_wdata_i = 32'd0; bus.resp_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #2 chk_en = 1'b1;
    chk("rst_req_ready", 32'(bus.req_ready_o), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid_o), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata_o, 32'd0);
    chk("rst_resp_err", 32'(bus.resp_err_o), 32'd0);
    chk("rst_irq_timer", 32'(irq_t), 32'd0);
    chk("rst_irq_sw", 32'(irq_s), 32'd0);
    rst = 1'b0;

    // 40 cycles at TICK_DIV=4 gives mtime=10
    repeat (40) @(posedge clk);
    #2;
    xfer(1'b0, 16'hBFF8, 32'd0, rd, er); chk("mtime_after_40", rd, 32'd10);
    xfer(1'b0, 16'hBFFC, 32'd0, rd, er); chk("mtime_hi_zero", rd, 32'd0);
    xfer(1'b0, 16'h4000, 32'd0, rd, er); chk("cmp_lo_reset", rd, 32'hFFFF_FFFF);
    xfer(1'b0, 16'h4004, 32'd0, rd, er); chk("cmp_hi_reset", rd, 32'hFFFF_FFFF);

    // Low-half wrap carries into high half
    xfer(1'b1, 16'hBFF8, 32'hFFFF_FFFF, rd, er);
    xfer(1'b1, 16'hBFFC, 32'd0, rd, er);
    repeat (20) @(posedge clk);
    #2;
    xfer(1'b0, 16'hBFFC, 32'd0, rd, er); chk("mtime_wrap_hi", rd, 32'd1);

    // Software interrupt
    xfer(1'b1, 16'h0000, 32'h3, rd, er); chk("msip_set_irq", 32'(irq_s), 32'd1);
    xfer(1'b0, 16'h0000, 32'd0, rd, er); chk("msip_readback", rd, 32'd1);
    xfer(1'b1, 16'h0000, 32'd0, rd, er); chk("msip_clr_irq", 32'(irq_s), 32'd0);

    // Error accesses leave state untouched
    xfer(1'b0, 16'h0004, 32'd0, rd, er);
    chk("err_0004", 32'(er), 32'd1); chk("err_0004_rdata", rd, 32'd0);
    xfer(1'b0, 16'h4002, 32'd0, rd, er);
    chk("err_4002", 32'(er), 32'd1); chk("err_4002_rdata", rd, 32'd0);
    xfer(1'b1, 16'h4002, 32'd0, rd, er); chk("err_wr_4002", 32'(er), 32'd1);
    xfer(1'b0, 16'h4000, 32'd0, rd, er); chk("cmp_untouched", rd, 32'hFFFF_FFFF);

    // Timer compare at 20
    do_reset();
    xfer(1'b1, 16'h4004, 32'd0, rd, er);
    xfer(1'b1, 16'h4000, 32'd20, rd, er);
    n = 0;
    while (!irq_t && n < 200) begin @(posedge clk); #2; n++; end
    chk("irq_timer_seen", 32'(irq_t), 32'd1);
    xfer(1'b0, 16'hBFF8, 32'd0, rd, er); chk("mtime_at_irq", rd, 32'd20);
    xfer(1'b1, 16'h4004, 32'd1, rd, er); chk("irq_timer_drop", 32'(irq_t), 32'd0);

    // Backpressure: response held while resp_ready is low
    bus.resp_ready_i = 1'b0;
    bus.req_valid_i = 1'b1; bus.req_we_i = 1'b0; bus.req_addr_i = 16'h4000;
    @(posedge clk); #2;
    bus.req_addr_i = 16'h4004;
    for (int i = 0; i < 3; i++) begin
      chk("bp_req_ready", 32'(bus.req_ready_o), 32'd0);
      chk("bp_resp_valid", 32'(bus.resp_valid_o), 32'd1);
      chk("bp_rdata", bus.resp_rdata_o, 32'd20);
      @(posedge clk); #2;
    end
    bus.resp_ready_i = 1'b1;
    #1 chk("bp_release_ready", 32'(bus.req_ready_o), 32'd1);
    @(posedge clk); #2;
    bus.req_valid_i = 1'b0;
    chk("bp_second_valid", 32'(bus.resp_valid_o), 32'd1);
    chk("bp_second_rdata", bus.resp_rdata_o, 32'd1);
    @(posedge clk); #2;
    chk("bp_drained", 32'(bus.resp_valid_o), 32'd0);

    // Async reset while a response is pending
    bus.resp_ready_i = 1'b0;
    bus.req_valid_i = 1'b1; bus.req_addr_i = 16'h0000;
    @(posedge clk); #2;
    bus.req_valid_i = 1'b0;
    chk("pend_resp_valid", 32'(bus.resp_valid_o), 32'd1);
    rst = 1'b1;
    #1 chk("async_rst_drop", 32'(bus.resp_valid_o), 32'd0);
    @(posedge clk); #2;
    rst = 1'b0; bus.resp_ready_i = 1'b1;

    // Random traffic; master holds a request until it is accepted
    held = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!held) begin
        bus.req_valid_i = ($urandom_range(0, 2) != 0);
        bus.req_we_i    = $urandom_range(0, 1) == 1;
        bus.req_addr_i  = alist[$urandom_range(0, 7)];
        bus.req_wdata_i = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 60)) : $urandom;
        if (bus.req_addr_i[2] && $urandom_range(0, 3) != 0) bus.req_wdata_i = 32'd0;
      end
      bus.resp_ready_i = ($urandom_range(0, 3) != 0);
      #1 held = bus.req_valid_i && !bus.req_ready_o;
      @(posedge clk); #2;
    end
    bus.req_valid_i = 1'b0; bus.resp_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #2 chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/clint_timer.md
# clint_timer

Core-local interruptor: machine timer (64-bit `mtime`/`mtimecmp`) and machine software-interrupt register (`msip`), memory-mapped on a single-outstanding valid/ready slave port. Sits beside the core and drives the `irq_timer_i` / `irq_software_i` inputs of the CSR file, which latches them into `mip`. It is the interrupt source end of that interface.

## Interface
- `TICK_DIV`, 1: clock cycles per `mtime` increment (≥1).
- `clk_i` in 1: clock; one clock; reset is asynchronous and active-high.
- `rst_i` in 1: reset, asynchronous, active-high.
- `req_valid_i` in 1: request valid.
- `req_ready_o` out 1: request accepted when both high.
- `req_we_i` in 1: 1 write, 0 read.
- `req_addr_i` in 16: byte offset in CLINT window.
- `req_wdata_i` in 32: write data (full-word only).
- `resp_valid_o` out 1: response valid; held until accepted.
- `resp_ready_i` in 1: response consumed when both high.
- `resp_rdata_o` out 32: read data (0 for writes/errors).
- `resp_err_o` out 1: unmapped or misaligned address.
- `irq_timer_o` out 1: machine timer interrupt, level.
- `irq_software_o` out 1: machine software interrupt, level.

## Operation
- Map: 0x0000 `msip` (bit0 RW, bits 31:1 read 0); 0x4000/0x4004 `mtimecmp` low/high; 0xBFF8/0xBFFC `mtime` low/high. Anything else, or `addr[1:0]≠0` → `resp_err_o=1`, no state change, rdata 0.
- Prescaler: counter 0..TICK_DIV-1; `tick` when count==TICK_DIV-1, then wraps to 0. TICK_DIV=1 → tick every cycle. Prescaler is never reset by software writes.
- `mtime`: +1 (64-bit, wraps 0xFFFF_FFFF_FFFF_FFFF→0) on tick. Software write to either half replaces that half only; write has priority, no increment that cycle (the other half also holds).
- `mtimecmp`: written by halves; no atomicity; software sequences hi/lo.
- `irq_timer_o` = registered (`mtime >= mtimecmp`, unsigned 64-bit) evaluated on current register values.
- `irq_software_o` = `msip[0]`.
- Handshake: `req_ready_o = !resp_valid_o || resp_ready_i`. On accept: write updates register at that edge; `resp_valid_o` rises next cycle with captured rdata/err. Read data = register value in the accept cycle (before same-edge update/increment).
- Response state: IDLE (resp_valid_o=0) → RESP on accept; RESP → IDLE on resp_ready_i with no new accept; RESP → RESP on resp_ready_i with back-to-back accept (new data loaded).

## Timing
- Reset values: `mtime`=0, `mtimecmp`=0xFFFF_FFFF_FFFF_FFFF, `msip`=0, prescaler=0, `req_ready_o`=1, `resp_valid_o`=0, `resp_rdata_o`=0, `resp_err_o`=0, `irq_timer_o`=0, `irq_software_o`=0.
- Request→response latency 1 cycle; full throughput 1 req/cycle with `resp_ready_i` tied high.
- `irq_timer_o` asserts 1 cycle after the edge where `mtime` reaches `mtimecmp`; deasserts 1 cycle after a write raises `mtimecmp` above `mtime`.
- `irq_software_o` changes on the edge that accepts the `msip` write.
- Reset mid-response drops `resp_valid_o` immediately (async); pending response lost.
- Requests while `req_ready_o=0` are ignored; master holds them.

## Test plan
- Reset → all outputs at reset values; read 0x4000/0x4004 → 0xFFFF_FFFF each; read 0xBFF8 after reset release returns cycles elapsed.
- TICK_DIV=4, run 40 cycles → `mtime`=10; write 0xBFF8=0xFFFF_FFFF, 0xBFFC=0 then 4 ticks → `mtime` low wraps, high=1.
- Write `mtimecmp`=20 (hi=0 first) → `irq_timer_o` rises 1 cycle after `mtime`=20; write cmp hi=1 → drops next cycle.
- Write 0x0000=0x3 → `irq_software_o`=1, read back 0x1; write 0 → deasserts.
- Read 0x0004 and 0x4002 → `resp_err_o`=1, rdata 0, no state change.
- Hold `resp_ready_i`=0 3 cycles with back-to-back requests → `req_ready_o`=0, response stable; release → second request accepted same cycle, 1 response per cycle after.
